// File: rtl/decode_imm_sequencer.sv
// decode_imm_sequencer: IF/ID register with 1-entry skid buffer and immediate-extender select decode
module decode_imm_sequencer #(
  parameter int CNT_W = 16,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      InstrF,
  input  logic [31:0]      PCF,
  input  logic             ValidF,
  output logic             ReadyF,
  input  logic             FlushD,
  input  logic             ReadyE,
  output logic             ValidD,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCD,
  output logic [24:0]      ImmD,
  output logic [2:0]       ImmSrcD,
  output logic             ImmUsedD,
  output logic             IllegalD,
  output logic [CNT_W-1:0] StallCntD
);
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  state_t state;
  logic [31:0] main_instr, main_pc, skid_instr, skid_pc;
  logic in_beat, out_beat;
  logic [2:0] imm_src;
  logic imm_used, illegal;
  assign ReadyF = state != SKID;
  assign ValidD = state != EMPTY;
  assign in_beat = ValidF && ReadyF;
  assign out_beat = ValidD && ReadyE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      main_instr <= NOP_INSTR;
      main_pc <= '0;
      skid_instr <= NOP_INSTR;
      skid_pc <= '0;
      StallCntD <= '0;
    end else begin
      if (ValidD && !ReadyE && !(&StallCntD)) StallCntD <= StallCntD + 1'b1;
      if (FlushD) state <= EMPTY;
      else case (state)
        EMPTY: if (in_beat) begin
          state <= FULL;
          main_instr <= InstrF;
          main_pc <= PCF;
        end
        FULL: if (in_beat && out_beat) begin
          main_instr <= InstrF;
          main_pc <= PCF;
        end else if (in_beat) begin
          state <= SKID;
          skid_instr <= InstrF;
          skid_pc <= PCF;
        end else if (out_beat) state <= EMPTY;
        SKID: if (out_beat) begin
          state <= FULL;
          main_instr <= skid_instr;
          main_pc <= skid_pc;
        end
        default: state <= EMPTY;
      endcase
    end
  always_comb begin
    imm_src = 3'b000;
    imm_used = 1'b0;
    illegal = 1'b0;
    case (main_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: imm_used = 1'b1;
      7'b0100011: begin imm_src = 3'b001; imm_used = 1'b1; end
      7'b1100011: begin imm_src = 3'b010; imm_used = 1'b1; end
      7'b1101111: begin imm_src = 3'b011; imm_used = 1'b1; end
      7'b0110111, 7'b0010111: begin imm_src = 3'b100; imm_used = 1'b1; end
      7'b0110011: imm_used = 1'b0;
      default: illegal = 1'b1;
    endcase
  end
  assign InstrD = ValidD ? main_instr : NOP_INSTR;
  assign PCD = ValidD ? main_pc : '0;
  assign ImmD = InstrD[31:7];
  assign ImmSrcD = ValidD ? imm_src : 3'b000;
  assign ImmUsedD = ValidD && imm_used;
  assign IllegalD = ValidD && illegal;
endmodule
